// File: rtl/io_button_ctrl.sv
// Button/switch front-end: per-channel synchronizer, debounce FSM, press/release/long pulses,
// sticky press events with write-one-to-clear and a maskable interrupt.
module io_button_ctrl #(
    parameter int unsigned    SW     = 1,
    parameter logic           DS     = 1'b0,
    parameter int unsigned    DCW    = 16,
    parameter logic [DCW-1:0] DB_CYC = DCW'(50000),
    parameter int unsigned    HCW    = 24,
    parameter logic [HCW-1:0] LP_CYC = HCW'(0)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [SW-1:0] io_i,
    input  logic [SW-1:0] irq_en_i,
    input  logic [SW-1:0] evt_clr_i,
    output logic [SW-1:0] state_o,
    output logic [SW-1:0] press_o,
    output logic [SW-1:0] release_o,
    output logic [SW-1:0] long_o,
    output logic [SW-1:0] evt_o,
    output logic          irq_o
);

    localparam logic [DCW-1:0] DB_LAST = DB_CYC - DCW'(1);
    localparam logic [HCW-1:0] LP_LAST = LP_CYC - HCW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRS_DB = 2'd1,
        HELD   = 2'd2,
        REL_DB = 2'd3
    } state_e;

    logic [SW-1:0]  sync1_q, sync1_d;
    logic [SW-1:0]  sync2_q, sync2_d;
    logic [SW-1:0]  act;

    state_e         state_q [SW];
    state_e         state_d [SW];
    logic [DCW-1:0] dcnt_q  [SW];
    logic [DCW-1:0] dcnt_d  [SW];
    logic [HCW-1:0] hcnt_q  [SW];
    logic [HCW-1:0] hcnt_d  [SW];

    logic [SW-1:0]  held_q, held_d;
    logic [SW-1:0]  press_q, press_d;
    logic [SW-1:0]  release_q, release_d;
    logic [SW-1:0]  long_q, long_d;
    logic [SW-1:0]  evt_q, evt_d;
    logic           irq_q, irq_d;

    // Two-flop synchronizer; act is the polarity-normalised pin level.
    always_comb begin
        sync1_d = io_i;
        sync2_d = sync1_q;
    end

    assign act = sync2_q ^ {SW{DS}};

    // Per-channel debounce FSM and hold counter.
    always_comb begin
        for (int n = 0; n < SW; n++) begin
            state_d[n]   = state_q[n];
            dcnt_d[n]    = dcnt_q[n];
            hcnt_d[n]    = hcnt_q[n];
            press_d[n]   = 1'b0;
            release_d[n] = 1'b0;
            long_d[n]    = 1'b0;

            case (state_q[n])
                IDLE: begin
                    if (act[n]) begin
                        state_d[n] = PRS_DB;
                        dcnt_d[n]  = '0;
                    end
                end
                PRS_DB: begin
                    if (!act[n]) begin
                        state_d[n] = IDLE;
                    end else if (dcnt_q[n] == DB_LAST) begin
                        state_d[n] = HELD;
                        press_d[n] = 1'b1;
                        hcnt_d[n]  = '0;
                    end else begin
                        dcnt_d[n] = dcnt_q[n] + DCW'(1);
                    end
                end
                HELD: begin
                    if (!act[n]) begin
                        state_d[n] = REL_DB;
                        dcnt_d[n]  = '0;
                    end
                end
                REL_DB: begin
                    if (act[n]) begin
                        state_d[n] = HELD;
                    end else if (dcnt_q[n] == DB_LAST) begin
                        state_d[n]   = IDLE;
                        release_d[n] = 1'b1;
                    end else begin
                        dcnt_d[n] = dcnt_q[n] + DCW'(1);
                    end
                end
                default: begin
                    state_d[n] = IDLE;
                end
            endcase

            // Hold time accrues while active; saturation makes long_o one-shot per press.
            if ((state_q[n] == HELD || state_q[n] == REL_DB) && state_d[n] != IDLE
                && hcnt_q[n] != LP_CYC) begin
                hcnt_d[n] = hcnt_q[n] + HCW'(1);
                long_d[n] = (hcnt_q[n] == LP_LAST);
            end

            held_d[n] = (state_d[n] == HELD) || (state_d[n] == REL_DB);
        end
    end

    // Set covers both the edge raising press_o and the cycle it is high, so an
    // overlapping clear never drops the event.
    always_comb begin
        evt_d = (evt_q & ~evt_clr_i) | press_d | press_q;
        irq_d = |(evt_q & irq_en_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= {SW{DS}};
            sync2_q   <= {SW{DS}};
            held_q    <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            evt_q     <= '0;
            irq_q     <= 1'b0;
            for (int n = 0; n < SW; n++) begin
                state_q[n] <= IDLE;
                dcnt_q[n]  <= '0;
                hcnt_q[n]  <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            held_q    <= held_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            evt_q     <= evt_d;
            irq_q     <= irq_d;
            for (int n = 0; n < SW; n++) begin
                state_q[n] <= state_d[n];
                dcnt_q[n]  <= dcnt_d[n];
                hcnt_q[n]  <= hcnt_d[n];
            end
        end
    end

    assign state_o   = held_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
    assign evt_o     = evt_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_io_button_ctrl.sv
// Directed bench for io_button_ctrl: a 2-channel active-high instance and a
// 1-channel active-low instance with long press disabled.
module tb_io_button_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, rst_n_b;
    logic [1:0] io_a, irq_en_a, clr_a;
    logic [1:0] state_a, press_a, release_a, long_a, evt_a;
    logic       irq_a;
    logic [0:0] io_b, irq_en_b, clr_b;
    logic [0:0] state_b, press_b, release_b, long_b, evt_b;
    logic       irq_b;

    int checks = 0;
    int errors = 0;

    io_button_ctrl #(
        .SW(2), .DS(1'b0), .DCW(16), .DB_CYC(16'd4), .HCW(24), .LP_CYC(24'd10)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .io_i(io_a), .irq_en_i(irq_en_a), .evt_clr_i(clr_a),
        .state_o(state_a), .press_o(press_a), .release_o(release_a), .long_o(long_a),
        .evt_o(evt_a), .irq_o(irq_a)
    );

    io_button_ctrl #(
        .SW(1), .DS(1'b1), .DCW(16), .DB_CYC(16'd4), .HCW(24), .LP_CYC(24'd0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n_b), .io_i(io_b), .irq_en_i(irq_en_b), .evt_clr_i(clr_b),
        .state_o(state_b), .press_o(press_b), .release_o(release_b), .long_o(long_b),
        .evt_o(evt_b), .irq_o(irq_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst_n_b = 1'b0;
        io_a = 2'b00; irq_en_a = 2'b01; clr_a = 2'b00;
        io_b = 1'b1;  irq_en_b = 1'b1;  clr_b = 1'b0;
        repeat (3) step();
        checks++;
        if ({state_a, press_a, release_a, long_a, evt_a, irq_a} !== 11'b0) begin
            errors++;
            $display("FAIL reset_a: got %b exp 0", {state_a, press_a, release_a, long_a, evt_a, irq_a});
        end
        checks++;
        if ({state_b, press_b, release_b, long_b, evt_b, irq_b} !== 6'b0) begin
            errors++;
            $display("FAIL reset_b: got %b exp 0", {state_b, press_b, release_b, long_b, evt_b, irq_b});
        end
        rst_n = 1'b1; rst_n_b = 1'b1;
        repeat (4) step();
        checks++;
        if ({state_a, press_a, evt_a, irq_a} !== 7'b0 || {state_b, press_b, evt_b} !== 3'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got a=%b b=%b exp 0",
                     {state_a, press_a, evt_a, irq_a}, {state_b, press_b, evt_b});
        end
    endtask

    task automatic test_glitch();
        io_a = 2'b01;
        repeat (3) step();
        io_a = 2'b00;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (press_a !== 2'b00 || state_a !== 2'b00) begin
                errors++;
                $display("FAIL glitch i=%0d: got press=%b state=%b exp 00/00", i, press_a, state_a);
            end
        end
    endtask

    task automatic test_press();
        logic [1:0] exp_p;
        io_a = 2'b01;
        for (int e = 0; e <= 6; e++) begin
            step();
            exp_p = (e == 6) ? 2'b01 : 2'b00;
            checks++;
            if (press_a !== exp_p) begin
                errors++;
                $display("FAIL press_latency e=%0d: got %b exp %b", e, press_a, exp_p);
            end
        end
        checks++;
        if (state_a !== 2'b01 || evt_a !== 2'b01 || irq_a !== 1'b0) begin
            errors++;
            $display("FAIL press_flags: got state=%b evt=%b irq=%b exp 01/01/0", state_a, evt_a, irq_a);
        end
        step();
        checks++;
        if (press_a !== 2'b00 || irq_a !== 1'b1) begin
            errors++;
            $display("FAIL press_irq: got press=%b irq=%b exp 00/1", press_a, irq_a);
        end
    endtask

    task automatic test_long_press();
        logic [1:0] exp_l;
        // press_o was at edge 6; hold continues to edge 31 (25 cycles after press)
        for (int e = 8; e <= 31; e++) begin
            step();
            exp_l = (e == 16) ? 2'b01 : 2'b00;
            checks++;
            if (long_a !== exp_l || state_a !== 2'b01) begin
                errors++;
                $display("FAIL long_press e=%0d: got long=%b state=%b exp %b/01", e, long_a, state_a, exp_l);
            end
        end
    endtask

    task automatic test_release_bounce();
        logic [1:0] exp_r, exp_s;
        io_a = 2'b00;
        for (int e = 0; e <= 11; e++) begin
            if (e == 3) io_a = 2'b01;
            if (e == 5) io_a = 2'b00;
            step();
            exp_r = (e == 11) ? 2'b01 : 2'b00;
            exp_s = (e == 11) ? 2'b00 : 2'b01;
            checks++;
            if (press_a !== 2'b00 || release_a !== exp_r || state_a !== exp_s || long_a !== 2'b00) begin
                errors++;
                $display("FAIL release_bounce e=%0d: got press=%b rel=%b state=%b long=%b exp 00/%b/%b/00",
                         e, press_a, release_a, state_a, long_a, exp_r, exp_s);
            end
        end
    endtask

    task automatic test_evt_clear();
        clr_a = 2'b01;
        step();
        checks++;
        if (evt_a !== 2'b00 || irq_a !== 1'b1) begin
            errors++;
            $display("FAIL clear_alone: got evt=%b irq=%b exp 00/1", evt_a, irq_a);
        end
        clr_a = 2'b00;
        step();
        checks++;
        if (evt_a !== 2'b00 || irq_a !== 1'b0) begin
            errors++;
            $display("FAIL clear_irq_drop: got evt=%b irq=%b exp 00/0", evt_a, irq_a);
        end
        io_a = 2'b01;
        repeat (7) step();
        checks++;
        if (press_a !== 2'b01 || evt_a !== 2'b01) begin
            errors++;
            $display("FAIL repress: got press=%b evt=%b exp 01/01", press_a, evt_a);
        end
        clr_a = 2'b01;
        step();
        clr_a = 2'b00;
        checks++;
        if (evt_a !== 2'b01) begin
            errors++;
            $display("FAIL clear_vs_set: got evt=%b exp 01", evt_a);
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] exp_p, exp_r;
        // ch0 releases 8 cycles after its press (short of LP_CYC), ch1 presses
        io_a = 2'b10;
        for (int e = 0; e <= 10; e++) begin
            if (e == 7) clr_a = 2'b01;
            if (e == 8) clr_a = 2'b00;
            step();
            exp_p = (e == 6) ? 2'b10 : 2'b00;
            exp_r = (e == 6) ? 2'b01 : 2'b00;
            checks++;
            if (press_a !== exp_p || release_a !== exp_r || long_a !== 2'b00) begin
                errors++;
                $display("FAIL simultaneous e=%0d: got press=%b rel=%b long=%b exp %b/%b/00",
                         e, press_a, release_a, long_a, exp_p, exp_r);
            end
            if (e == 6) begin
                checks++;
                if (state_a !== 2'b10 || evt_a !== 2'b11) begin
                    errors++;
                    $display("FAIL simul_flags: got state=%b evt=%b exp 10/11", state_a, evt_a);
                end
            end
            if (e == 7) begin
                checks++;
                if (evt_a !== 2'b10 || irq_a !== 1'b1) begin
                    errors++;
                    $display("FAIL simul_clear: got evt=%b irq=%b exp 10/1", evt_a, irq_a);
                end
            end
            if (e == 8) begin
                checks++;
                if (irq_a !== 1'b0) begin
                    errors++;
                    $display("FAIL irq_mask: got irq=%b exp 0", irq_a);
                end
            end
        end
    endtask

    task automatic test_ds_reset();
        logic exp_p;
        io_b = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            step();
            exp_p = (e == 6);
            checks++;
            if (press_b !== exp_p) begin
                errors++;
                $display("FAIL ds_press e=%0d: got %b exp %b", e, press_b, exp_p);
            end
        end
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (long_b !== 1'b0 || state_b !== 1'b1) begin
                errors++;
                $display("FAIL lp_disabled i=%0d: got long=%b state=%b exp 0/1", i, long_b, state_b);
            end
        end
        io_b = 1'b1;
        repeat (7) step();
        checks++;
        if (release_b !== 1'b1 || state_b !== 1'b0 || evt_b !== 1'b1 || irq_b !== 1'b1) begin
            errors++;
            $display("FAIL ds_release: got rel=%b state=%b evt=%b irq=%b exp 1/0/1/1",
                     release_b, state_b, evt_b, irq_b);
        end
        io_b = 1'b0;
        repeat (3) step();
        rst_n_b = 1'b0;
        #1;
        checks++;
        if ({state_b, press_b, release_b, long_b, evt_b, irq_b} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset: got %b exp 0", {state_b, press_b, release_b, long_b, evt_b, irq_b});
        end
        repeat (2) step();
        rst_n_b = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            step();
            exp_p = (e == 6);
            checks++;
            if (press_b !== exp_p) begin
                errors++;
                $display("FAIL post_reset_press e=%0d: got %b exp %b", e, press_b, exp_p);
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_press();
        test_long_press();
        test_release_bounce();
        test_evt_clear();
        test_simultaneous();
        test_ds_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
